// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, ALU codes,
// datapath mux selects and the opcodes the controller recognises.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_SUB    = 2'b01,
        ALU_OP_DECODE = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: fixed add/sub for address and compare steps, or a
// funct3/funct7 decode for R-type and I-type execution.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_DECODE: begin
                case (funct3)
                    3'b000:  alu_control = (op_5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I datapath.
// Optional build macro RISCV_BNE_EN: branch taken = zero ^ funct3[0] (beq/bne).
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_t  state;
    logic    illegal_q;
    alu_op_t alu_op;
    logic    taken;
    logic    pc_en;
    logic    ir_en;
    logic    mem_en;
    logic    reg_en;
    logic    unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

`ifdef RISCV_BNE_EN
    assign taken = zero ^ funct3[0];
`else
    assign taken = zero;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_ITYPE:          state <= S_EXECI;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
                        default: begin
                            state     <= S_FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        mem_en     = 1'b0;
        reg_en     = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_OP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_en      = mem_ready;
                ir_en      = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_en     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_en  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_DECODE;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_DECODE;
            end
            S_ALUWB:    reg_en = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_SUB;
                pc_en     = taken;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_en     = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating enables with rst kills a pending write in the same cycle reset asserts.
    assign pc_write      = pc_en  & rst;
    assign ir_write      = ir_en  & rst;
    assign mem_write     = mem_en & rst;
    assign reg_write     = reg_en & rst;
    assign illegal_instr = illegal_q;
    assign imm_src       = imm_src_of(op);

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_5        (op[5]),
        .funct7_5    (funct7[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: per-cycle vectors with
// hand-derived expected outputs, plus a reset-during-store sequence.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] SYS = 7'b1110011;
    localparam logic [1:0] II = 2'b00, IS = 2'b01, IB = 2'b10, IJ = 2'b11;
`ifdef RISCV_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       illegal_instr;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       zero;
        logic       mem_ready;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b1;
    logic pc_write, adr_src, ir_write, mem_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int n_checks = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .funct7        (funct7),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr)
    );

    function automatic out_t mk(input logic pcw, input logic adr, input logic irw,
                                input logic mw, input logic rw, input logic [1:0] res,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] imm, input logic [2:0] alu, input logic ill);
        out_t r;
        r = {pcw, adr, irw, mw, rw, res, a, b, imm, alu, ill};
        return r;
    endfunction

    // Expected output patterns for each state, written out by hand.
    function automatic out_t e_fetch(input logic rdy, input logic [1:0] imm, input logic ill);
        return mk(rdy, 0, rdy, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, ill);
    endfunction
    function automatic out_t e_decode(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
    endfunction
    function automatic out_t e_memadr(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0);
    endfunction
    function automatic out_t e_memread();
        return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, II, 3'b000, 0);
    endfunction
    function automatic out_t e_memwb();
        return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, II, 3'b000, 0);
    endfunction
    function automatic out_t e_memwrite();
        return mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, IS, 3'b000, 0);
    endfunction
    function automatic out_t e_execr(input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, II, alu, 0);
    endfunction
    function automatic out_t e_execi(input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, II, alu, 0);
    endfunction
    function automatic out_t e_aluwb(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
    endfunction
    function automatic out_t e_branch(input logic pcw);
        return mk(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IB, 3'b001, 0);
    endfunction
    function automatic out_t e_jal();
        return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, IJ, 3'b000, 0);
    endfunction

    function automatic out_t sample();
        return {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic rdy, input out_t exp);
        vec_t v;
        v.op = o; v.funct3 = f3; v.funct7 = f7; v.zero = z; v.mem_ready = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Drive one cycle's inputs just after the edge, compare mid-cycle.
    task automatic step(input vec_t v, input string name);
        op = v.op; funct3 = v.funct3; funct7 = v.funct7; zero = v.zero; mem_ready = v.mem_ready;
        @(negedge clk);
        check(name, sample(), v.exp);
        @(posedge clk);
        #1;
    endtask

    // Single R-type/I-type instruction with a plain fetch and writeback.
    task automatic add_alu(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] alu);
        add(o, f3, f7, 0, 1, e_fetch(1, II, 0));
        add(o, f3, f7, 0, 1, e_decode(II));
        add(o, f3, f7, 0, 1, (o == RT) ? e_execr(alu) : e_execi(alu));
        add(o, f3, f7, 0, 1, e_aluwb(II));
    endtask

    task automatic add_branch(input logic [2:0] f3, input logic z, input logic pcw);
        add(BR, f3, 7'h00, z, 1, e_fetch(1, IB, 0));
        add(BR, f3, 7'h00, z, 1, e_decode(IB));
        add(BR, f3, 7'h00, z, 1, e_branch(pcw));
    endtask

    initial begin
        // lw, no stalls: 5 cycles, reg_write with result_src=01 only in the last
        add(LW, 3'd2, 7'h00, 0, 1, e_fetch(1, II, 0));
        add(LW, 3'd2, 7'h00, 0, 1, e_decode(II));
        add(LW, 3'd2, 7'h00, 0, 1, e_memadr(II));
        add(LW, 3'd2, 7'h00, 0, 1, e_memread());
        add(LW, 3'd2, 7'h00, 0, 1, e_memwb());
        // sw with three stalled MEMWRITE cycles
        add(SW, 3'd2, 7'h00, 0, 1, e_fetch(1, IS, 0));
        add(SW, 3'd2, 7'h00, 0, 1, e_decode(IS));
        add(SW, 3'd2, 7'h00, 0, 1, e_memadr(IS));
        for (int k = 0; k < 3; k++) add(SW, 3'd2, 7'h00, 0, 0, e_memwrite());
        add(SW, 3'd2, 7'h00, 0, 1, e_memwrite());
        add_alu(RT, 3'b000, 7'h20, 3'b001);
        add_alu(RT, 3'b000, 7'h00, 3'b000);
        add_alu(RT, 3'b110, 7'h00, 3'b011);
        add_alu(RT, 3'b010, 7'h00, 3'b101);
        add_alu(IT, 3'b000, 7'h20, 3'b000);
        add_alu(IT, 3'b111, 7'h00, 3'b010);
        add_branch(3'b000, 1, 1);
        add_branch(3'b000, 0, 0);
        add_branch(3'b001, 0, BNE_EN);
        add_branch(3'b001, 1, !BNE_EN);
        add(JL, 3'd0, 7'h00, 0, 1, e_fetch(1, IJ, 0));
        add(JL, 3'd0, 7'h00, 0, 1, e_decode(IJ));
        add(JL, 3'd0, 7'h00, 0, 1, e_jal());
        add(JL, 3'd0, 7'h00, 0, 1, e_aluwb(IJ));
        add(SYS, 3'd0, 7'h00, 0, 1, e_fetch(1, II, 0));
        add(SYS, 3'd0, 7'h00, 0, 1, e_decode(II));
        // illegal pulse lands on the next (stalled) fetch and lasts one cycle
        add(LW, 3'd2, 7'h00, 0, 0, e_fetch(0, II, 1));
        add(LW, 3'd2, 7'h00, 0, 0, e_fetch(0, II, 0));
        add(LW, 3'd2, 7'h00, 0, 1, e_fetch(1, II, 0));
        add(LW, 3'd2, 7'h00, 0, 1, e_decode(II));
        add(LW, 3'd2, 7'h00, 0, 1, e_memadr(II));
        add(LW, 3'd2, 7'h00, 0, 0, e_memread());
        add(LW, 3'd2, 7'h00, 0, 1, e_memread());
        add(LW, 3'd2, 7'h00, 0, 1, e_memwb());
        // store that will be cut short by reset
        add(SW, 3'd2, 7'h00, 0, 1, e_fetch(1, IS, 0));
        add(SW, 3'd2, 7'h00, 0, 1, e_decode(IS));
        add(SW, 3'd2, 7'h00, 0, 1, e_memadr(IS));
        add(SW, 3'd2, 7'h00, 0, 0, e_memwrite());

        #12;
        check("reset_state", sample(), e_fetch(0, II, 0));
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Still in MEMWRITE: reset must drop mem_write at once and show FETCH selects
        mem_ready = 1'b1;
        #1;
        check("mw_before_rst", sample(), e_memwrite());
        rst = 1'b0;
        #1;
        check("mw_in_rst", sample(), e_fetch(0, IS, 0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("fetch_after_rst", sample(), e_fetch(1, IS, 0));
        @(posedge clk);
        #1;
        step(tbl[1 + 5], "decode_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle RV32I core. It replaces the single-cycle control path with a Moore FSM that steps the shared datapath through fetch, decode, execute, memory and writeback over 3–5 states per instruction. It stalls on a memory ready handshake and drives every mux select and write enable, including the PC, IR, register file and memory.

## Interface
- No parameters; encodings live in the shared package.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `op`  in  7  opcode, taken from the instruction register
- `funct3`  in  3  instruction bits [14:12]
- `funct7`  in  7  instruction bits [31:25]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  unified memory has completed the current access
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  instruction register and OldPC enable
- `mem_write`  out  1  memory write strobe
- `reg_write`  out  1  register file write enable
- `result_src`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `alu_src_a`  out  2  ALU source A: 00 = PC, 01 = OldPC, 10 = rs1 register
- `alu_src_b`  out  2  ALU source B: 00 = rs2 register, 01 = immediate, 10 = constant 4
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `illegal_instr`  out  1  one-cycle pulse when the opcode is unsupported

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- FETCH: adr_src=0, A=00, B=10, add, result_src=10.
  - ir_write and pc_write assert only when mem_ready=1.
  - Advance to DECODE only on mem_ready=1; otherwise hold.
- DECODE: A=01, B=01, add. This computes the branch/jump target into ALUOut.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other op → FETCH, with illegal_instr pulsed for 1 cycle
- MEMADR: A=10, B=01, add. Next state is MEMREAD for op 0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state is FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Hold with mem_write high until mem_ready=1, then go to FETCH.
- EXECR: A=10, B=00, R-type decode. Next state is ALUWB.
- EXECI: A=10, B=01, I-type decode. Next state is ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state is FETCH.
- BRANCH: A=10, B=00, sub, result_src=00. pc_write = taken. Next state is FETCH.
- JAL: A=01, B=10, add, result_src=00, pc_write=1. Next state is ALUWB, which writes PC+4 to rd.
- imm_src is combinational from op: load/I-type 00, store 01, branch 10, jal 11, otherwise 00.
- ALU decode (for EXECR and EXECI):
  - funct3 000: sub when op[5] & funct7[5], else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Other funct3 values: add.
- Selects not listed for a state are 00. Enables not listed for a state are 0.

## Timing
- Outputs are Moore decodes of the state register. The exceptions are pc_write and ir_write in FETCH (gated by mem_ready) and pc_write in BRANCH (gated by zero).
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - branch: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable during a stall.
- Reset (rst=0): state goes to FETCH asynchronously.
  - Every enable output is ANDed with rst, so enables read 0 during reset.
  - Select outputs show FETCH values: adr_src=0, A=00, B=10, result_src=10, alu_control=000.
  - illegal_instr=0.
- A reset asserted mid-instruction aborts it immediately. A pending mem_write deasserts in the same cycle.
- illegal_instr is registered: it is high in the FETCH cycle that follows the offending DECODE.

## Configuration
- `RISCV_BNE_EN` defined: in BRANCH, taken = zero ^ funct3[0]. This gives beq (funct3 000) and bne (funct3 001).
- `RISCV_BNE_EN` undefined: taken = zero, and funct3 is ignored. bne behaves as beq.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum
  - ALU control codes
  - result_src, alu_src_a, alu_src_b and imm_src codes
  - opcode constants: LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL
- One sub-module, `mc_alu_decoder`, with inputs alu_op[1:0], funct3, op[5], funct7[5] and output alu_control. The FSM drives alu_op: 00 = add, 01 = sub, 10 = decode.

## Test plan
- Reset mid-MEMWRITE (rst low for 1 cycle) → mem_write=0 immediately; FETCH is the next state.
- lw (op 0000011) with mem_ready=1 → 5 cycles; reg_write=1 with result_src=01 in cycle 5 only.
- sw with mem_ready=0 for 3 cycles in MEMWRITE → mem_write high for 4 cycles, then FETCH.
- R-type sub (funct3 000, funct7 0100000) → alu_control=001 in EXECR; add (funct7 0) → 000; I-type funct3 000 with funct7[5]=1 → 000.
- beq with zero=1 → pc_write=1 in BRANCH; zero=0 → 0. With RISCV_BNE_EN, funct3 001 and zero=0 → pc_write=1.
- Opcode 1110011 → DECODE to FETCH, illegal_instr high for exactly 1 cycle, no write enables asserted.
